noc_local_firewall: RTL
=======================

# noc_local_firewall

Flit-level security filter on the local injection path. It sits between the CNI link controller's router-bound output and local input port 4 of the mesh router. Every flit the NI injects is checked for source spoofing, an allowed destination window and an injection-rate budget. Passing flits are buffered and forwarded under router backpressure; failing flits are dropped, counted and flagged.

## Interface
Parameters:
- XY_WIDTH, 2, width of one mesh coordinate
- FLIT_WIDTH, 40, flit width; layout {src_x, src_y, dst_x, dst_y, payload}, coordinates at the MSBs
- FIFO_DEPTH, 4, forward buffer entries (power of 2, ≥2)
- RATE_WINDOW, 64, refill period of the rate budget in cycles
- RATE_MAX, 32, tokens per window (1..RATE_WINDOW)
- CNT_WIDTH, 16, width of the drop counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- myx, myy  in  XY_WIDTH each  this node's coordinates
- fw_enable  in  1  1 = apply checks; 0 = transparent pass-through
- allow_xmin, allow_xmax, allow_ymin, allow_ymax  in  XY_WIDTH each  inclusive allowed destination rectangle
- in_data  in  FLIT_WIDTH  flit from the link controller
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  backpressure to the link controller; 1 = flit accepted this cycle
- out_data  out  FLIT_WIDTH  flit to router in4
- out_valid  out  1  to router in_valid4
- out_bp  in  1  router BPo_4; 1 = router can take a flit
- anomaly_clear  in  1  synchronous clear of flags and drop counter
- anomaly_detected  out  2  sticky; [0] spoof/region violation, [1] rate violation
- drop_count  out  CNT_WIDTH  saturating count of dropped flits

## Operation
- Accept is in_valid & in_ready. in_ready = (FIFO count < FIFO_DEPTH). No full-and-popping bypass: when the FIFO is full, in_ready stays 0 even if a pop occurs in the same cycle.
- Checks are combinational on the accepted flit:
  - spoof: src ≠ {myx,myy}
  - region: dst outside [allow_xmin..allow_xmax] × [allow_ymin..allow_ymax]
  - rate: tokens == 0
- Priority: spoof/region sets bit [0]. Rate is evaluated only if spoof/region passes, and sets bit [1].
- Pass: push to the FIFO and consume one token.
- Fail: do not push, drop_count +1 (saturates at all-ones), set the corresponding anomaly bit.
- fw_enable=0: every accepted flit is pushed. No tokens are consumed, no counter or flag changes. The window counter keeps running.
- Token bucket:
  - window counter wraps at RATE_WINDOW-1
  - on wrap, tokens reload to RATE_MAX
  - reload and consume in the same cycle yields RATE_MAX-1
  - tokens never underflow
- Output: out_data = FIFO head. out_valid = ~empty & out_bp. A pop occurs whenever out_valid=1.
- anomaly_clear zeroes both flags and drop_count. A violation in the same cycle wins: its flag is set and drop_count = 1.
- Push and pop in the same cycle with a non-full FIFO: count unchanged, order preserved.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, anomaly_detected=0, drop_count=0
  - tokens=RATE_MAX, window counter=0, FIFO empty
- Latency: a flit accepted in cycle N appears on out_data with out_valid in cycle N+1 if out_bp=1 and it is at the head. Throughput is 1 flit/cycle.
- Flags and drop_count update in the cycle after the violating accept.
- Reset asserted mid-operation: buffered flits are discarded and all state returns to reset values immediately (asynchronous).
- allow_* and fw_enable are sampled every cycle and take effect at the next accept.

## Configuration
- FW_RATE_LIMIT_EN defined: token bucket and window counter are built, and rate drops set anomaly_detected[1].
- FW_RATE_LIMIT_EN undefined: no rate state, no rate drops, anomaly_detected[1] tied to 0. Spoof/region behaviour is unchanged.

## Structure
- constants.v holds `FLIT_WIDTH, `XY_WIDTH and the new field-offset macros FW_SRCX_MSB … FW_DSTY_LSB. These are shared with pack/depack so the flit layout has a single definition.
- Sub-module noc_fw_fifo: synchronous FIFO, parameterized width/depth, asynchronous active-low reset. Ports: push, pop, din, dout, count, full, empty.

## Test plan
- Clean traffic: myx=1, myy=1, window 0..3, fw_enable=1; 8 back-to-back flits src (1,1) dst (2,3), out_bp=1 → same 8 flits in order starting 1 cycle later, drop_count=0, anomaly=00.
- Spoof: one flit src (0,1) between two good flits → spoofed flit absent at output, drop_count=1, anomaly=01 the next cycle. It stays set until anomaly_clear; a clear pulse then returns anomaly=00 and drop_count=0.
- Region: window x 0..1, flit dst (3,0) → dropped, anomaly[0]=1. With fw_enable=0 the same flit is forwarded and drop_count is unchanged.
- Backpressure: out_bp=0, FIFO_DEPTH=4, 6 valid flits offered → 4 accepted, then in_ready=0 until out_bp=1. All 4 delivered in order and no flit is lost.
- Rate (FW_RATE_LIMIT_EN, RATE_MAX=4, RATE_WINDOW=16): 6 good flits in a burst → 4 forwarded, 2 dropped, anomaly=10. After the window wraps, 4 more pass.
- Reset mid-burst: assert rst with 3 flits buffered → out_valid=0 at once, nothing is emitted after release, tokens=RATE_MAX.

Source files
------------

// File: rtl/noc_local_firewall_pkg.sv
// Shared types and helpers for the local injection firewall.
// Flit layout is {src_x, src_y, dst_x, dst_y, payload}, with the coordinates at the MSBs.
package noc_local_firewall_pkg;

  // Anomaly flag bit positions.
  localparam int unsigned AnomSpoofRegion = 0;
  localparam int unsigned AnomRate        = 1;
  localparam int unsigned AnomWidth       = 2;

  // Check outcome. The encoding is one-hot onto the anomaly flag bits, so a drop can OR it in.
  typedef enum logic [AnomWidth-1:0] {
    ChkPass        = 2'b00,
    ChkSpoofRegion = 2'b01,
    ChkRate        = 2'b10
  } chk_result_e;

  // Inclusive range test. An empty range (lo > hi) matches nothing.
  function automatic logic fw_in_range(input int unsigned val, input int unsigned lo,
                                       input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/noc_fw_fifo.sv
// Synchronous forward buffer for the firewall; power-of-2 depth, first-word-fall-through head.
module noc_fw_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic [$clog2(Depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state: write at wptr, advance pointers, net count change.
  always_comb begin
    mem_d = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d = wptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AddrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noc_local_firewall.sv
// Flit-level security filter between the NI link controller and router local port 4.
// Checks source spoofing, destination window and (optionally) an injection-rate budget.
// Optional feature macro: FW_RATE_LIMIT_EN builds the token bucket and rate drops.
module noc_local_firewall
  import noc_local_firewall_pkg::*;
#(
  parameter int unsigned XY_WIDTH    = 2,
  parameter int unsigned FLIT_WIDTH  = 40,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RATE_WINDOW = 64,
  parameter int unsigned RATE_MAX    = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XY_WIDTH-1:0]   myx,
  input  logic [XY_WIDTH-1:0]   myy,
  input  logic                  fw_enable,
  input  logic [XY_WIDTH-1:0]   allow_xmin,
  input  logic [XY_WIDTH-1:0]   allow_xmax,
  input  logic [XY_WIDTH-1:0]   allow_ymin,
  input  logic [XY_WIDTH-1:0]   allow_ymax,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_bp,
  input  logic                  anomaly_clear,
  output logic [AnomWidth-1:0]  anomaly_detected,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  // Field offsets; the coordinate block sits at the top of the flit.
  localparam int unsigned FwSrcxMsb = FLIT_WIDTH - 1;
  localparam int unsigned FwSrcyMsb = FLIT_WIDTH - 1 - XY_WIDTH;
  localparam int unsigned FwDstxMsb = FLIT_WIDTH - 1 - 2 * XY_WIDTH;
  localparam int unsigned FwDstyMsb = FLIT_WIDTH - 1 - 3 * XY_WIDTH;
  localparam int unsigned FifoCntW  = $clog2(FIFO_DEPTH) + 1;

  logic [XY_WIDTH-1:0]  src_x, src_y, dst_x, dst_y;
  logic [FifoCntW-1:0]  fifo_count;
  logic                 fifo_empty, unused_fifo_full;
  logic                 accept, push, pop, drop;
  logic                 sr_fail, rate_fail;
  chk_result_e          chk;
  logic [AnomWidth-1:0] anomaly_q, anomaly_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  assign src_x = in_data[FwSrcxMsb -: XY_WIDTH];
  assign src_y = in_data[FwSrcyMsb -: XY_WIDTH];
  assign dst_x = in_data[FwDstxMsb -: XY_WIDTH];
  assign dst_y = in_data[FwDstyMsb -: XY_WIDTH];

  // No full-and-popping bypass: readiness depends on occupancy only.
  assign in_ready  = (fifo_count < FifoCntW'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty & out_bp;
  assign pop       = out_valid;

  assign sr_fail = (src_x != myx) | (src_y != myy) |
                   ~fw_in_range(32'(dst_x), 32'(allow_xmin), 32'(allow_xmax)) |
                   ~fw_in_range(32'(dst_y), 32'(allow_ymin), 32'(allow_ymax));

`ifdef FW_RATE_LIMIT_EN
  localparam int unsigned TokW = $clog2(RATE_MAX + 1);
  localparam int unsigned WinW = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;

  logic [TokW-1:0] tokens_q, tokens_d;
  logic [WinW-1:0] win_q, win_d;
  logic            win_wrap, consume;

  assign rate_fail = (tokens_q == '0);
  assign consume   = accept & fw_enable & ~sr_fail & ~rate_fail;

  // Window counter free-runs; the wrap reloads the bucket, a same-cycle consume still counts.
  always_comb begin
    win_wrap = (win_q == WinW'(RATE_WINDOW - 1));
    win_d    = win_wrap ? '0 : win_q + WinW'(1);
    tokens_d = win_wrap ? TokW'(RATE_MAX) : tokens_q;
    if (consume) tokens_d = tokens_d - TokW'(1);
  end

  // Token bucket state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tokens_q <= TokW'(RATE_MAX);
      win_q    <= '0;
    end else begin
      tokens_q <= tokens_d;
      win_q    <= win_d;
    end
  end
`else
  localparam int unsigned unused_rate_cfg = RATE_WINDOW + RATE_MAX;
  assign rate_fail = 1'b0;
`endif

  // Spoof/region takes priority; rate is only judged on an otherwise clean flit.
  always_comb begin
    chk = ChkPass;
    if (sr_fail) begin
      chk = ChkSpoofRegion;
    end else if (rate_fail) begin
      chk = ChkRate;
    end
  end

  assign push = accept & (~fw_enable | (chk == ChkPass));
  assign drop = accept & fw_enable & (chk != ChkPass);

  // Sticky flags and saturating drop counter; a drop in the clear cycle survives the clear.
  always_comb begin
    anomaly_d  = anomaly_q;
    drop_cnt_d = drop_cnt_q;
    if (anomaly_clear) begin
      anomaly_d  = '0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      anomaly_d = anomaly_d | AnomWidth'(chk);
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_WIDTH'(1);
    end
  end

  // Anomaly reporting state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anomaly_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      anomaly_q  <= anomaly_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign anomaly_detected = anomaly_q;
  assign drop_count       = drop_cnt_q;

  noc_fw_fifo #(
    .Width (FLIT_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (out_data),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

endmodule
